// File: rtl/sipo32_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo32_loader_pkg
// Description : Shared types and constants for the sipo32_loader serial-to-
//               parallel front end: controller state encoding and the bit
//               counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo32_loader_pkg;

    // Controller state: IDLE waits for the first bit of a word, SHIFT holds a
    // partial word (bit count 1..WIDTH-1).
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    // Counter width able to hold the values 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo32_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo32_loader_if
// Description : Serial input, word output handshake and status signals of the
//               sipo32_loader.
//               slave  : the loader (samples serial input, drives word/flags)
//               master : the environment (drives serial input, consumes word)
// Ports       : sin, sin_en, frame_start, out_ready, clr_err  (to loader)
//               out_word, out_valid, busy, ovr, frame_err      (from loader)
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo32_loader_if #(
    parameter int WIDTH = 32
);
    logic             sin;
    logic             sin_en;
    logic             frame_start;
    logic             out_ready;
    logic             clr_err;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             busy;
    logic             ovr;
    logic             frame_err;

    modport slave (
        input  sin, sin_en, frame_start, out_ready, clr_err,
        output out_word, out_valid, busy, ovr, frame_err
    );

    modport master (
        output sin, sin_en, frame_start, out_ready, clr_err,
        input  out_word, out_valid, busy, ovr, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/sipo32_loader_shift.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift
// Description : WIDTH-bit serial-in shift register with direction select,
//               enable and synchronous clear. nxt is the value the register
//               takes on an enabled edge, so the caller can capture a word
//               on the same edge its last bit arrives.
// Ports       : clk, rst_n (async, active-low), en, clr, din -> nxt
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift
    import sipo32_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic             din,
    output logic      [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_base;

    // Clear together with enable starts a fresh word: din becomes bit 0.
    assign w_base = clr ? '0 : r_q;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign nxt = {w_base[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign nxt = {din, w_base[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= nxt;
        end else if (clr) begin
            r_q <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sipo32_loader.sv
`default_nettype none
// ============================================================================
// Module      : sipo32_loader
// Description : Assembles a bit-serial stream into WIDTH-bit words and offers
//               each completed word through a holding register on a
//               valid/ready handshake. Overruns and truncated frames raise
//               sticky flags cleared by clr_err.
// Ports       : clk  - rising-edge clock
//               R    - asynchronous active-low reset
//               bus  - sipo32_loader_if.slave (serial in, word out, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module sipo32_loader
    import sipo32_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input wire logic       clk,
    input wire logic       R,
    sipo32_loader_if.slave bus
);

    localparam int                 C_CNT_W = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_start;
    logic               w_complete;
    logic               w_frame_err_set;
    logic               w_ovr_set;
    logic               w_hold_free;
    logic [WIDTH-1:0]   w_shift_nxt;

    logic [WIDTH-1:0]   r_word;
    logic               r_valid;
    logic               r_ovr;
    logic               r_frame_err;

    sipo_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .rst_n (R),
        .en    (bus.sin_en),
        .clr   (w_start),
        .din   (bus.sin),
        .nxt   (w_shift_nxt)
    );

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A word starts on any enabled bit in IDLE, or on frame_start mid-word
    // (which abandons the partial word). With WIDTH >= 2 a starting bit can
    // never also complete a word.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_start         = 1'b0;
        w_complete      = 1'b0;
        w_frame_err_set = 1'b0;
        if (bus.sin_en) begin
            if (r_state == IDLE || bus.frame_start) begin
                w_start         = 1'b1;
                w_frame_err_set = (r_state == SHIFT);
                w_cnt_nxt       = C_ONE;
                w_state_nxt     = SHIFT;
            end else if (r_cnt == C_LAST) begin
                w_complete  = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt = r_cnt + C_ONE;
            end
        end
    end

    // Holding register is free if empty or being consumed this edge.
    assign w_hold_free = !r_valid || bus.out_ready;
    assign w_ovr_set   = w_complete && !w_hold_free;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (w_complete && w_hold_free) begin
            r_word  <= w_shift_nxt;
            r_valid <= 1'b1;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky flags; a set event outranks a clear on the same edge.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_ovr       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_ovr       <= (r_ovr && !bus.clr_err) || w_ovr_set;
            r_frame_err <= (r_frame_err && !bus.clr_err) || w_frame_err_set;
        end
    end

    assign bus.out_word  = r_word;
    assign bus.out_valid = r_valid;
    assign bus.busy      = (r_state == SHIFT);
    assign bus.ovr       = r_ovr;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_sipo32_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo32_loader
// Description : Self-checking bench. Two loaders (MSB-first and LSB-first)
//               receive the same serial stream; a word-level reference model
//               predicts words, handshake and flags every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo32_loader;

    logic clk = 1'b0;
    logic R;
    always #5 clk = ~clk;

    sipo32_loader_if #(.WIDTH(32)) bm ();
    sipo32_loader_if #(.WIDTH(32)) bl ();

    sipo32_loader #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .R(R), .bus(bm));
    sipo32_loader #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .R(R), .bus(bl));

    int n_assert = 0;
    int n_fail   = 0;
    int n_pulse  = 0;

    // Reference model: bits received so far, both word orders, holding reg.
    int          m_cnt;
    logic [31:0] m_acc_m, m_acc_l;
    logic [31:0] m_word_m, m_word_l;
    bit          m_valid, m_ovr, m_ferr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_acc_m = '0; m_acc_l = '0;
        m_word_m = '0; m_word_l = '0;
        m_valid = 0; m_ovr = 0; m_ferr = 0;
    endtask

    task automatic model_edge(input bit b, input bit en, input bit fs, input bit rdy, input bit clr);
        bit comp, ovr_set, ferr_set;
        comp = 0; ovr_set = 0; ferr_set = 0;
        if (en) begin
            if (m_cnt == 0 || fs) begin
                ferr_set = (m_cnt != 0);
                m_cnt   = 1;
                m_acc_m = 32'(b);
                m_acc_l = 32'(b);
            end else begin
                m_acc_m = (m_acc_m << 1) | 32'(b);
                m_acc_l = m_acc_l | (32'(b) << m_cnt);
                m_cnt++;
            end
            if (m_cnt == 32) begin
                comp  = 1;
                m_cnt = 0;
            end
        end
        if (comp) begin
            if (!m_valid || rdy) begin
                m_word_m = m_acc_m;
                m_word_l = m_acc_l;
                m_valid  = 1;
            end else begin
                ovr_set = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ovr  = (m_ovr  && !clr) || ovr_set;
        m_ferr = (m_ferr && !clr) || ferr_set;
    endtask

    task automatic check_all(input string ph);
        chk({ph, " m_valid"}, 32'(bm.out_valid), 32'(m_valid));
        chk({ph, " m_word"},  bm.out_word,       m_word_m);
        chk({ph, " m_busy"},  32'(bm.busy),      32'(m_cnt != 0));
        chk({ph, " m_ovr"},   32'(bm.ovr),       32'(m_ovr));
        chk({ph, " m_ferr"},  32'(bm.frame_err), 32'(m_ferr));
        chk({ph, " l_valid"}, 32'(bl.out_valid), 32'(m_valid));
        chk({ph, " l_word"},  bl.out_word,       m_word_l);
        chk({ph, " l_busy"},  32'(bl.busy),      32'(m_cnt != 0));
        chk({ph, " l_ovr"},   32'(bl.ovr),       32'(m_ovr));
        chk({ph, " l_ferr"},  32'(bl.frame_err), 32'(m_ferr));
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // compare 1 time unit later, return at the next falling edge.
    task automatic tick(input bit b, input bit en, input bit fs, input bit rdy, input bit clr,
                        input string ph);
        bm.sin = b; bm.sin_en = en; bm.frame_start = fs; bm.out_ready = rdy; bm.clr_err = clr;
        bl.sin = b; bl.sin_en = en; bl.frame_start = fs; bl.out_ready = rdy; bl.clr_err = clr;
        @(posedge clk);
        model_edge(b, en, fs, rdy, clr);
        #1;
        check_all(ph);
        if (bm.out_valid) n_pulse++;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit msb_first, input bit rdy,
                             input bit fs_first, input string ph);
        for (int i = 0; i < 32; i++) begin
            tick(msb_first ? w[31-i] : w[i], 1'b1, fs_first && (i == 0), rdy, 1'b0, ph);
        end
    endtask

    initial begin
        int p0;
        logic [31:0] rw;
        R = 1'b0;
        bm.sin = 0; bm.sin_en = 0; bm.frame_start = 0; bm.out_ready = 0; bm.clr_err = 0;
        bl.sin = 0; bl.sin_en = 0; bl.frame_start = 0; bl.out_ready = 0; bl.clr_err = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        R = 1'b1;

        // Bit order, MSB-first feed, then LSB-first feed.
        send_word(32'hA5C3_0F81, 1'b1, 1'b1, 1'b0, "order_msb");
        chk("order_msb word", bm.out_word, 32'hA5C30F81);
        chk("order_msb valid", 32'(bm.out_valid), 32'd1);
        tick(0, 0, 0, 1, 0, "order_msb drain");
        chk("order_msb one-cycle valid", 32'(bm.out_valid), 32'd0);
        send_word(32'hA5C3_0F81, 1'b0, 1'b1, 1'b0, "order_lsb");
        chk("order_lsb word", bl.out_word, 32'hA5C30F81);
        tick(0, 0, 0, 1, 0, "order_lsb drain");

        // Frame start while idle is a plain first bit, not an error.
        tick(1, 1, 1, 1, 0, "idle_fs");
        chk("idle_fs ferr", 32'(bm.frame_err), 32'd0);
        send_word(32'h0, 1'b1, 1'b1, 1'b1, "idle_fs flush");
        chk("idle_fs flush ferr", 32'(bm.frame_err), 32'd1);
        tick(0, 0, 0, 1, 1, "idle_fs clr");

        // Continuous stream, three pulses, no overrun.
        p0 = n_pulse;
        send_word(32'h0000_0001, 1'b1, 1'b1, 1'b0, "stream0");
        send_word(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, "stream1");
        send_word(32'h8000_0000, 1'b1, 1'b1, 1'b0, "stream2");
        chk("stream pulses", 32'(n_pulse - p0), 32'd3);
        chk("stream last word", bm.out_word, 32'h80000000);
        chk("stream ovr", 32'(bm.ovr), 32'd0);
        tick(0, 0, 0, 1, 0, "stream drain");

        // Overrun with consumer stalled.
        send_word(32'h1111_1111, 1'b1, 1'b0, 1'b0, "ovr0");
        send_word(32'h2222_2222, 1'b1, 1'b0, 1'b0, "ovr1");
        chk("ovr word held", bm.out_word, 32'h11111111);
        chk("ovr flag", 32'(bm.ovr), 32'd1);
        tick(0, 0, 0, 1, 0, "ovr accept");
        chk("ovr valid drop", 32'(bm.out_valid), 32'd0);
        chk("ovr sticky", 32'(bm.ovr), 32'd1);
        tick(0, 0, 0, 0, 1, "ovr clr");
        chk("ovr cleared", 32'(bm.ovr), 32'd0);

        // Truncated frame.
        for (int i = 0; i < 10; i++) tick(1'($urandom), 1, 0, 1, 0, "trunc pre");
        send_word(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, "trunc");
        chk("trunc ferr", 32'(bm.frame_err), 32'd1);
        chk("trunc word", bm.out_word, 32'hDEADBEEF);
        tick(0, 0, 0, 1, 1, "trunc clr");
        chk("trunc ferr clr", 32'(bm.frame_err), 32'd0);

        // Asynchronous reset mid-word at count 17 with a word held.
        send_word(32'h1234_5678, 1'b1, 1'b0, 1'b0, "rst held");
        for (int i = 0; i < 17; i++) tick(1'($urandom), 1, 0, 0, 0, "rst pre");
        chk("rst pre busy", 32'(bm.busy), 32'd1);
        #2;
        R = 1'b0;
        #1;
        model_reset();
        check_all("rst async");
        @(posedge clk);
        @(negedge clk);
        R = 1'b1;
        rw = $urandom;
        send_word(rw, 1'b1, 1'b1, 1'b0, "rst post");
        chk("rst post word", bm.out_word, rw);

        // Gapped random traffic.
        for (int i = 0; i < 2500; i++) begin
            tick(1'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 2,
                 1'($urandom), $urandom_range(0, 99) < 3, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo32_loader.md
# sipo32_loader

Serial-to-parallel front end that assembles a bit-serial input stream into WIDTH-bit words and presents each completed word on a valid/ready interface. It sits directly upstream of the 32-bit DFF-based register stage: `out_word` drives that register's data input, qualified by `out_valid`. A holding register decouples the shift path from the consumer, so shifting continues while a finished word waits. Overruns and truncated frames are flagged rather than silently lost.

## Interface
- WIDTH, 32, word length in bits; legal range 2..32
- MSB_FIRST, 1, 1: first received bit lands in `out_word[WIDTH-1]`; 0: first bit lands in `out_word[0]`
- clk  input  1  rising-edge clock
- R  input  1  reset, asynchronous, active-low; one clock, no other reset
- sin  input  1  serial data bit
- sin_en  input  1  `sin` is sampled on this edge when 1
- frame_start  input  1  qualified by `sin_en`; marks the current bit as bit 0 of a new word
- out_word  output  WIDTH  completed word, holding register
- out_valid  output  1  `out_word` holds an unconsumed word
- out_ready  input  1  consumer accepts `out_word` on an edge where `out_valid & out_ready`
- busy  output  1  a partial word is in the shift register (state SHIFT)
- ovr  output  1  sticky overrun flag
- frame_err  output  1  sticky truncated-frame flag
- clr_err  input  1  synchronous clear of `ovr` and `frame_err`

## Operation
- Reset values (R=0, immediate): state IDLE, bit count 0, shift register 0, `out_word`=0, `out_valid`=0, `busy`=0, `ovr`=0, `frame_err`=0.
- Reset mid-word discards the partial word and any held word; no flag is set.
- State IDLE:
  - `sin_en`=1 (with or without `frame_start`) takes `sin` as bit 0, count=1, go to SHIFT.
  - If WIDTH would be reached, the completion rule below applies instead.
- State SHIFT, on `sin_en`=1:
  - Shift in `sin`, count+1.
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1.
- State SHIFT, `frame_start` with `sin_en`: partial word discarded, `frame_err` set, current bit becomes bit 0, count=1.
- Completion: the bit making count=WIDTH completes the word; state returns to IDLE, count=0.
  - Holding register free (`out_valid`=0, or `out_valid & out_ready` on the same edge): assembled word loads into `out_word`, `out_valid`=1.
  - Holding register occupied with `out_ready`=0: new word is dropped, `out_word` unchanged, `ovr` set.
- Handshake: `out_valid & out_ready` with no completion on that edge clears `out_valid`; `out_word` keeps its last value. `out_ready` is ignored while `out_valid`=0.
- `sin_en`=0: no state, count or shift change.
- Flags:
  - `clr_err`=1 clears `ovr` and `frame_err`.
  - A set event on the same edge as `clr_err` wins.
  - Flags never self-clear.

## Timing
- Sampling: `sin`, `sin_en` and `frame_start` are sampled on the rising `clk` edge.
- Latency: the word is visible on `out_word`/`out_valid` immediately after the edge that samples its last bit. This is zero extra cycles; minimum word period is WIDTH cycles.
- Back-to-back:
  - With `out_ready` held 1 and `sin_en` held 1, `out_valid` pulses high for one cycle every WIDTH cycles with no gaps.
  - Completion on the same edge as acceptance keeps `out_valid`=1 with the new word.
- Outputs are registered; no combinational path from `out_ready` to any output.
- `busy`=1 exactly while count is in 1..WIDTH-1.

## Structure
- Shared package:
  - State encoding `IDLE`=1'b0, `SHIFT`=1'b1.
  - Count width constant `CNT_W`=$clog2(WIDTH+1).
- One natural sub-module, `sipo_shift`: the WIDTH-bit shift register with direction parameter, enable and synchronous clear.
- Controller, count, holding register and flags stay in the top.

## Test plan
- Reset: assert R=0 mid-word (count 17) -> all outputs 0 immediately; after release, the next 32 bits form a clean word.
- Order check:
  - MSB_FIRST=1: feed 0xA5C3_0F81 MSB first, `out_ready`=1 -> `out_word`=32'hA5C30F81, `out_valid` high exactly one cycle after bit 32.
  - MSB_FIRST=0: same bits fed LSB first -> `out_word`=32'hA5C30F81.
- Continuous stream: three words 0x00000001, 0xFFFFFFFF, 0x80000000, `sin_en` always 1, `out_ready`=1 -> three `out_valid` pulses spaced 32 cycles, no `ovr`.
- Overrun: hold `out_ready`=0 across two completed words 0x11111111 and 0x22222222 -> `out_word` stays 0x11111111, `ovr`=1. Then assert `out_ready` -> `out_valid` drops; `clr_err` -> `ovr`=0.
- Truncated frame: `frame_start` after 10 bits, then 32 bits of 0xDEADBEEF -> `frame_err`=1, `out_word`=0xDEADBEEF.
- Gapped input: `sin_en` random 30% duty, `out_ready` random -> scoreboard matches every accepted word, `ovr` only when the model predicts it.
